// File: rtl/sdp_triosy_pkg.sv
// Shared types and defaults for the SDP ALU config triosy responder.
// The watchdog width helper serves builds with SDP_TRIOSY_TIMEOUT_EN defined.
package sdp_triosy_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ACTIVE      = 2'd1,
        ACTIVE_PEND = 2'd2
    } state_e;

    localparam int unsigned DEF_DATA_W = 6;
    localparam int unsigned DEF_CNT_W  = 8;

    function automatic int unsigned wd_width(input int unsigned limit);
        int unsigned w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sdp_triosy_stage_reg.sv
// Single-entry staging register holding the next shift value while the
// presented one is still waiting for its lz pulse.
module sdp_triosy_stage_reg
    import sdp_triosy_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              unload,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // A full slot is never overwritten; load is ignored until unload.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (unload) begin
            valid_d = 1'b0;
        end else if (load && !valid_q) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/sdp_cfg_triosy_responder.sv
// Register-side responder for the SDP ALU config triosy channel.
// Optional watchdog enabled by defining SDP_TRIOSY_TIMEOUT_EN.
module sdp_cfg_triosy_responder
    import sdp_triosy_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic              reg_wr_en,
    input  logic [DATA_W-1:0] reg_wr_data,
    output logic              reg_wr_busy,
    output logic [DATA_W-1:0] cfg_rsc_dat,
    output logic              cfg_rsc_vld,
    input  logic              triosy_lz,
    output logic [CNT_W-1:0]  done_cnt,
    output logic              ack_err,
    input  logic              clr_err,
    output logic              timeout_err
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic              vld_q, vld_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic              stage_load, stage_unload, stage_vld;
    logic [DATA_W-1:0] stage_dat;
    logic              lz_acc, enter_active, err_ev;

    sdp_triosy_stage_reg #(.DATA_W(DATA_W)) u_stage (
        .clk       (nvdla_core_clk),
        .rst       (nvdla_core_rst),
        .load      (stage_load),
        .load_data (reg_wr_data),
        .unload    (stage_unload),
        .valid     (stage_vld),
        .data      (stage_dat)
    );

    always_comb begin
        state_d      = state_q;
        dat_d        = dat_q;
        vld_d        = vld_q;
        stage_load   = 1'b0;
        stage_unload = 1'b0;
        lz_acc       = 1'b0;
        enter_active = 1'b0;
        err_ev       = 1'b0;
        case (state_q)
            IDLE: begin
                if (triosy_lz) err_ev = 1'b1;
                if (reg_wr_en) begin
                    state_d      = ACTIVE;
                    dat_d        = reg_wr_data;
                    vld_d        = 1'b1;
                    enter_active = 1'b1;
                end
            end
            ACTIVE: begin
                if (triosy_lz) begin
                    lz_acc = 1'b1;
                    // Write coinciding with lz bypasses staging: no valid bubble.
                    if (reg_wr_en) begin
                        dat_d = reg_wr_data;
                    end else begin
                        vld_d   = 1'b0;
                        state_d = IDLE;
                    end
                end else if (reg_wr_en) begin
                    stage_load = 1'b1;
                    state_d    = ACTIVE_PEND;
                end
            end
            ACTIVE_PEND: begin
                if (reg_wr_en) err_ev = 1'b1;
                if (triosy_lz && stage_vld) begin
                    lz_acc       = 1'b1;
                    stage_unload = 1'b1;
                    dat_d        = stage_dat;
                    state_d      = ACTIVE;
                end
            end
            default: state_d = IDLE;
        endcase
        cnt_d = lz_acc ? cnt_q + 1'b1 : cnt_q;
        ack_d = err_ev ? 1'b1 : (clr_err ? 1'b0 : ack_q);
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q <= IDLE;
            dat_q   <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

`ifdef SDP_TRIOSY_TIMEOUT_EN
    localparam int unsigned WD_W = wd_width(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_q, to_d;

    always_comb begin
        wd_d = wd_q;
        if (lz_acc || enter_active) begin
            wd_d = '0;
        end else if (vld_q && wd_q != WD_LIMIT) begin
            wd_d = wd_q + 1'b1;
        end
        to_d = (vld_q && wd_d == WD_LIMIT) ? 1'b1 : (clr_err ? 1'b0 : to_q);
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign timeout_err = to_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign reg_wr_busy = (state_q == ACTIVE_PEND);
    assign cfg_rsc_dat = dat_q;
    assign cfg_rsc_vld = vld_q;
    assign done_cnt    = cnt_q;
    assign ack_err     = ack_q;

endmodule
